// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending sequencer.
package vend_pkg;

  localparam int unsigned CREDIT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StVend,
    StChange
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;
  localparam logic [1:0] COIN_FIVE = 2'b11;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] coin);
    logic [CREDIT_W-1:0] value;
    unique case (coin)
      COIN_ONE:  value = CREDIT_W'(1);
      COIN_TWO:  value = CREDIT_W'(2);
      COIN_FIVE: value = CREDIT_W'(5);
      default:   value = '0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/vend_arbiter.sv
// Two-way round-robin grant between purchase buttons A and B.
// grant_sel_o: 0 = A, 1 = B; only meaningful while grant_o is high.
module vend_arbiter (
  input  logic elig_a_i,
  input  logic elig_b_i,
  input  logic rr_ptr_i,
  output logic grant_o,
  output logic grant_sel_o
);

  always_comb begin
    grant_o     = elig_a_i | elig_b_i;
    grant_sel_o = (elig_a_i && elig_b_i) ? rr_ptr_i : elig_b_i;
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: coin credit, A/B purchase arbitration, dispense handshake
// with timeout, and unit-coin change payout.
module vend_sequencer #(
  parameter int unsigned PRICE_A = 5,
  parameter int unsigned PRICE_B = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] moneda,
  input  logic       comprarA,
  input  logic       comprarB,
  input  logic       cancel,
  input  logic       vend_done,
  input  logic       pay_ack,
  output logic       vend_req,
  output logic       vend_sel,
  output logic       pay_req,
  output logic       coin_rej,
  output logic [3:0] total,
  output logic       listoA,
  output logic       listoB,
  output logic       fault
);

  import vend_pkg::*;

  localparam logic [CREDIT_W-1:0] PriceA      = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PriceB      = CREDIT_W'(PRICE_B);
  localparam logic [7:0]          TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        rr_ptr_q;
  logic [7:0]  cnt_q;

  logic            elig_a, elig_b, grant, grant_sel;
  logic [CREDIT_W:0] coin_sum;

  always_comb begin
    elig_a   = comprarA && (total >= PriceA);
    elig_b   = comprarB && (total >= PriceB);
    coin_sum = {1'b0, total} + {1'b0, coin_value(moneda)};
  end

  vend_arbiter u_arbiter (
    .elig_a_i    (elig_a),
    .elig_b_i    (elig_b),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_sel_o (grant_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      total    <= '0;
      vend_req <= 1'b0;
      vend_sel <= 1'b0;
      pay_req  <= 1'b0;
      coin_rej <= 1'b0;
      listoA   <= 1'b0;
      listoB   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      coin_rej <= 1'b0;
      listoA   <= 1'b0;
      listoB   <= 1'b0;
      if (state_q != StIdle && moneda != COIN_NONE) coin_rej <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (grant) begin
            // A starting vend swallows any coin presented in the same cycle.
            total    <= total - (grant_sel ? PriceB : PriceA);
            vend_req <= 1'b1;
            vend_sel <= grant_sel;
            cnt_q    <= '0;
            state_q  <= StVend;
          end else begin
            if (moneda != COIN_NONE) begin
              if (coin_sum[CREDIT_W]) coin_rej <= 1'b1;
              else                    total    <= coin_sum[CREDIT_W-1:0];
            end
            if (cancel && total != '0) begin
              pay_req <= 1'b1;
              state_q <= StChange;
            end
          end
        end

        StVend: begin
          cnt_q <= cnt_q + 8'd1;
          if (vend_done) begin
            vend_req <= 1'b0;
            listoA   <= ~vend_sel;
            listoB   <= vend_sel;
            rr_ptr_q <= ~vend_sel;
            if (total != '0) begin
              pay_req <= 1'b1;
              state_q <= StChange;
            end else begin
              state_q <= StIdle;
            end
          end else if (cnt_q == TimeoutLast) begin
            // Motor stuck: refund the full price through the hopper.
            fault    <= 1'b1;
            vend_req <= 1'b0;
            total    <= total + (vend_sel ? PriceB : PriceA);
            pay_req  <= 1'b1;
            state_q  <= StChange;
          end
        end

        StChange: begin
          if (total == '0) begin
            pay_req <= 1'b0;
            state_q <= StIdle;
          end else if (pay_ack) begin
            total <= total - 1'b1;
            if (total == CREDIT_W'(1)) begin
              pay_req <= 1'b0;
              state_q <= StIdle;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
